// File: rtl/led_ctrl_pkg.sv
// Shared types and helpers for the LED mode controller.
//   mode_t    : pattern selected for led[0] (OFF, ON, SLOW, FAST, BREATHE)
//   MODE_W    : width of the mode encoding
//   PWM_W     : width of the breathe PWM counter and duty value
//   next_mode : successor of a mode on a step press (wraps BREATHE -> OFF)
package led_ctrl_pkg;

  localparam int MODE_W = 3;
  localparam int PWM_W  = 8;

  typedef enum logic [MODE_W-1:0] {
    MODE_OFF     = 3'd0,
    MODE_ON      = 3'd1,
    MODE_SLOW    = 3'd2,
    MODE_FAST    = 3'd3,
    MODE_BREATHE = 3'd4
  } mode_t;

  // Encodings 5-7 cannot be reached by stepping; if one ever appears it
  // falls back to OFF.
  function automatic mode_t next_mode(input mode_t m);
    case (m)
      MODE_OFF:     return MODE_ON;
      MODE_ON:      return MODE_SLOW;
      MODE_SLOW:    return MODE_FAST;
      MODE_FAST:    return MODE_BREATHE;
      MODE_BREATHE: return MODE_OFF;
      default:      return MODE_OFF;
    endcase
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Synchroniser, debouncer and press detector for one active-low button.
//   clk   : system clock
//   rst   : asynchronous active-low reset
//   btn_n : raw button, active low, asynchronous to clk
//   level : debounced button level (1 = released)
//   press : one-cycle pulse the cycle after level falls 1 -> 0
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic level,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             level_d_reg;

  // Everything resets to "released", so a button already held at reset
  // release must still survive a full debounce window before it counts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_reg    <= 2'b11;
      cnt_reg     <= '0;
      level       <= 1'b1;
      level_d_reg <= 1'b1;
      press       <= 1'b0;
    end else begin
      sync_reg    <= {sync_reg[0], btn_n};
      level_d_reg <= level;
      press       <= level_d_reg & ~level;
      // Any sample that agrees with the accepted level restarts the window.
      if (sync_reg[1] == level) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CNT_LAST) begin
        level   <= sync_reg[1];
        cnt_reg <= '0;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/led_mode_ctrl.sv
// Owner of the board's two LEDs.
//   clk     : system clock
//   rst     : asynchronous active-low reset
//   button  : raw active-low buttons; [0] steps the mode, [1] forces OFF
//   led     : registered LED drives; [0] mode pattern, [1] heartbeat/ack
//   mode_o  : current mode encoding
//   press_o : one-cycle accepted-press pulse per button
module led_mode_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500_000,
  parameter int SLOW_HALF       = 50_000_000,
  parameter int FAST_HALF       = 12_500_000,
  parameter int BREATHE_STEP    = 50_000,
  parameter int FEEDBACK_CYCLES = 5_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        button,
  output logic [1:0]        led,
  output logic [MODE_W-1:0] mode_o,
  output logic [1:0]        press_o
);

  localparam int SLOW_W = (SLOW_HALF > 1) ? $clog2(SLOW_HALF) : 1;
  localparam int FAST_W = (FAST_HALF > 1) ? $clog2(FAST_HALF) : 1;
  localparam int STEP_W = (BREATHE_STEP > 1) ? $clog2(BREATHE_STEP) : 1;
  localparam int FB_W   = $clog2(FEEDBACK_CYCLES + 1) > 0 ? $clog2(FEEDBACK_CYCLES + 1) : 1;

  localparam logic [SLOW_W-1:0] SLOW_LAST = SLOW_W'(SLOW_HALF - 1);
  localparam logic [FAST_W-1:0] FAST_LAST = FAST_W'(FAST_HALF - 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(BREATHE_STEP - 1);
  localparam logic [FB_W-1:0]   FB_LOAD   = FB_W'(FEEDBACK_CYCLES);
  localparam logic [PWM_W-1:0]  DUTY_MAX  = {PWM_W{1'b1}};

  logic [1:0]        btn_level;
  mode_t             mode_reg;
  logic [SLOW_W-1:0] slow_cnt_reg;
  logic [FAST_W-1:0] fast_cnt_reg;
  logic [STEP_W-1:0] step_cnt_reg;
  logic [PWM_W-1:0]  pwm_cnt_reg;
  logic [PWM_W-1:0]  duty_reg;
  logic              dir_up_reg;
  logic              slow_ph_reg;
  logic              fast_ph_reg;
  logic [FB_W-1:0]   fb_reg;
  logic [FB_W-1:0]   fb_next;
  logic              led0_next;
  logic              step_wrap;
  logic              enter_breathe;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_btn
      button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
        .clk  (clk),
        .rst  (rst),
        .btn_n(button[gi]),
        .level(btn_level[gi]),
        .press(press_o[gi])
      );
    end
  endgenerate

  assign mode_o    = mode_reg;
  assign step_wrap = (step_cnt_reg == STEP_LAST);
  // The only way into BREATHE is a lone step press while in FAST.
  assign enter_breathe = press_o[0] & ~press_o[1] & (mode_reg == MODE_FAST);

  always_comb begin
    fb_next = fb_reg;
    if (|press_o) begin
      fb_next = FB_LOAD;
    end else if (fb_reg != '0) begin
      fb_next = fb_reg - 1'b1;
    end
  end

  always_comb begin
    led0_next = 1'b0;
    case (mode_reg)
      MODE_ON:      led0_next = 1'b1;
      MODE_SLOW:    led0_next = slow_ph_reg;
      MODE_FAST:    led0_next = fast_ph_reg;
      MODE_BREATHE: led0_next = (pwm_cnt_reg < duty_reg);
      default:      led0_next = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_reg     <= MODE_OFF;
      slow_cnt_reg <= '0;
      fast_cnt_reg <= '0;
      step_cnt_reg <= '0;
      pwm_cnt_reg  <= '0;
      duty_reg     <= '0;
      dir_up_reg   <= 1'b1;
      slow_ph_reg  <= 1'b0;
      fast_ph_reg  <= 1'b0;
      fb_reg       <= '0;
      led          <= 2'b00;
    end else begin
      // Timebases free-run; mode changes never restart them.
      if (slow_cnt_reg == SLOW_LAST) begin
        slow_cnt_reg <= '0;
        slow_ph_reg  <= ~slow_ph_reg;
      end else begin
        slow_cnt_reg <= slow_cnt_reg + 1'b1;
      end
      if (fast_cnt_reg == FAST_LAST) begin
        fast_cnt_reg <= '0;
        fast_ph_reg  <= ~fast_ph_reg;
      end else begin
        fast_cnt_reg <= fast_cnt_reg + 1'b1;
      end
      step_cnt_reg <= step_wrap ? '0 : step_cnt_reg + 1'b1;
      pwm_cnt_reg  <= pwm_cnt_reg + 1'b1;

      // Mode FSM: the OFF button has priority over the step button.
      if (press_o[1]) begin
        mode_reg <= MODE_OFF;
      end else if (press_o[0]) begin
        mode_reg <= next_mode(mode_reg);
      end else if (mode_reg > MODE_BREATHE) begin
        mode_reg <= MODE_OFF;
      end

      // Triangle duty: turn around at both ends without repeating them.
      if (mode_reg != MODE_BREATHE) begin
        if (enter_breathe) begin
          duty_reg   <= '0;
          dir_up_reg <= 1'b1;
        end
      end else if (step_wrap) begin
        if (dir_up_reg) begin
          if (duty_reg == DUTY_MAX) begin
            duty_reg   <= DUTY_MAX - 1'b1;
            dir_up_reg <= 1'b0;
          end else begin
            duty_reg <= duty_reg + 1'b1;
          end
        end else begin
          if (duty_reg == '0) begin
            duty_reg   <= 1;
            dir_up_reg <= 1'b1;
          end else begin
            duty_reg <= duty_reg - 1'b1;
          end
        end
      end

      fb_reg <= fb_next;
      led    <= {(fb_next != '0) | slow_ph_reg, led0_next};
    end
  end

endmodule

// File: tb/tb_led_mode_ctrl.sv
// Testbench for led_mode_ctrl with small timing parameters.
module tb_led_mode_ctrl;

  localparam int D    = 4;
  localparam int SH   = 10;
  localparam int FH   = 3;
  localparam int FBC  = 6;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] button = 2'b11;
  logic [1:0] led;
  logic [2:0] mode_o;
  logic [1:0] press_o;

  int n_checks = 0;
  int n_errors = 0;

  led_mode_ctrl #(
    .DEBOUNCE_CYCLES(D),
    .SLOW_HALF(SH),
    .FAST_HALF(FH),
    .BREATHE_STEP(1),
    .FEEDBACK_CYCLES(FBC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .button(button),
    .led(led),
    .mode_o(mode_o),
    .press_o(press_o)
  );

  always #5 clk = ~clk;

  // Reference model: expected outputs after each rising edge, derived from
  // elapsed edge counts and the history of sampled button levels.
  int         m_k;
  int         m_mode;
  int         m_j;
  int         m_last_press;
  bit [7:0]   m_hist [2];
  bit         m_lvl  [2];
  bit         m_fell [2];
  bit [1:0]   m_press;
  bit [1:0]   m_led;

  function automatic int tri_duty(input int j);
    int t;
    t = j % 510;
    return (t <= 255) ? t : 510 - t;
  endfunction

  always @(posedge clk or negedge rst) begin
    int kp;
    int mp;
    bit [1:0] pp;
    bit l0;
    bit l1;
    bit all_diff;
    if (!rst) begin
      m_k = 0; m_mode = 0; m_j = 0; m_last_press = -1000;
      m_press = 2'b00; m_led = 2'b00;
      for (int b = 0; b < 2; b++) begin
        m_hist[b] = 8'hFF; m_lvl[b] = 1'b1; m_fell[b] = 1'b0;
      end
    end else begin
      kp = m_k; mp = m_mode; pp = m_press;
      m_k = kp + 1;
      case (mp)
        0:       l0 = 1'b0;
        1:       l0 = 1'b1;
        2:       l0 = ((kp / SH) % 2) != 0;
        3:       l0 = ((kp / FH) % 2) != 0;
        default: l0 = (kp % 256) < tri_duty(m_j);
      endcase
      if (pp[1]) m_mode = 0;
      else if (pp[0]) m_mode = (mp + 1) % 5;
      if (mp != 4 && m_mode == 4) m_j = 0;
      else if (mp == 4) m_j = m_j + 1;
      if (pp != 2'b00) m_last_press = m_k;
      l1 = ((m_k - m_last_press) < FBC) ? 1'b1 : (((kp / SH) % 2) != 0);
      m_led = {l1, l0};
      for (int b = 0; b < 2; b++) begin
        m_press[b] = m_fell[b];
        m_fell[b]  = 1'b0;
        all_diff = 1'b1;
        for (int i = 1; i <= D; i++) if (m_hist[b][i] == m_lvl[b]) all_diff = 1'b0;
        if (all_diff) begin
          m_lvl[b]  = ~m_lvl[b];
          m_fell[b] = (m_lvl[b] == 1'b0);
        end
        m_hist[b] = {m_hist[b][6:0], button[b]};
      end
    end
  end

  task automatic test_reset();
    rst = 1'b0; button = 2'b11;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_checks++;
      if (led !== 2'b00 || mode_o !== 3'd0 || press_o !== 2'b00) begin
        n_errors++;
        $display("FAIL reset_hold c=%0d led=%b mode=%0d press=%b required 00/0/00", c, led, mode_o, press_o);
      end
    end
    rst = 1'b1;
    for (int c = 0; c < 45; c++) begin
      @(negedge clk);
      n_checks++;
      if (led !== m_led || mode_o !== 3'(m_mode) || press_o !== m_press) begin
        n_errors++;
        $display("FAIL heartbeat c=%0d led=%b/%b mode=%0d/%0d press=%b/%b", c, led, m_led, mode_o, m_mode, press_o, m_press);
      end
    end
  endtask

  task automatic test_debounce();
    int seen;
    int first;
    for (int g = 0; g < 4; g++) begin
      int len;
      int b;
      len = (g == 0) ? 3 : int'($urandom_range(1, 3));
      b   = (g == 0) ? 0 : int'($urandom_range(0, 1));
      seen = 0;
      button[b] = 1'b0;
      for (int c = 0; c < len + 12; c++) begin
        @(negedge clk);
        if (press_o != 2'b00) seen++;
        n_checks++;
        if (led !== m_led || mode_o !== 3'(m_mode) || press_o !== m_press) begin
          n_errors++;
          $display("FAIL glitch g=%0d c=%0d led=%b/%b mode=%0d/%0d press=%b/%b", g, c, led, m_led, mode_o, m_mode, press_o, m_press);
        end
        if (c == len - 1) button = 2'b11;
      end
      n_checks++;
      if (seen !== 0 || mode_o !== 3'd0) begin
        n_errors++;
        $display("FAIL glitch_nopress g=%0d len=%0d pulses=%0d mode=%0d required 0/0", g, len, seen, mode_o);
      end
    end
    first = -1;
    button[0] = 1'b0;
    for (int c = 1; c <= 24; c++) begin
      @(negedge clk);
      if (press_o[0] && first < 0) first = c;
      n_checks++;
      if (led !== m_led || mode_o !== 3'(m_mode) || press_o !== m_press) begin
        n_errors++;
        $display("FAIL press_latency c=%0d led=%b/%b mode=%0d/%0d press=%b/%b", c, led, m_led, mode_o, m_mode, press_o, m_press);
      end
      if (c == 12) button = 2'b11;
    end
    n_checks++;
    if (first !== 7 || mode_o !== 3'd1) begin
      n_errors++;
      $display("FAIL press_edge first_pulse_cycle=%0d mode=%0d required 7/1", first, mode_o);
    end
  endtask

  task automatic test_mode_cycle();
    int exp_tab [6] = '{0, 1, 2, 3, 4, 0};
    for (int p = 0; p < 6; p++) begin
      int lo;
      int hi;
      lo = 6 + int'($urandom_range(0, 4));
      hi = 8 + int'($urandom_range(0, 4)) + 25;
      button = (p == 0) ? 2'b01 : 2'b10;
      for (int c = 0; c < lo + hi; c++) begin
        @(negedge clk);
        n_checks++;
        if (led !== m_led || mode_o !== 3'(m_mode) || press_o !== m_press) begin
          n_errors++;
          $display("FAIL mode_cycle p=%0d c=%0d led=%b/%b mode=%0d/%0d press=%b/%b", p, c, led, m_led, mode_o, m_mode, press_o, m_press);
        end
        if (c == lo - 1) button = 2'b11;
      end
      n_checks++;
      if (mode_o !== 3'(exp_tab[p])) begin
        n_errors++;
        $display("FAIL mode_step p=%0d mode=%0d required %0d", p, mode_o, exp_tab[p]);
      end
    end
  endtask

  task automatic test_override();
    int n_both;
    int n_single;
    for (int p = 0; p < 4; p++) begin
      int lo;
      lo = 6 + int'($urandom_range(0, 3));
      button = (p < 3) ? 2'b10 : 2'b00;
      n_both = 0; n_single = 0;
      for (int c = 0; c < lo + 30; c++) begin
        @(negedge clk);
        if (press_o == 2'b11) n_both++;
        if (press_o == 2'b01 || press_o == 2'b10) n_single++;
        n_checks++;
        if (led !== m_led || mode_o !== 3'(m_mode) || press_o !== m_press) begin
          n_errors++;
          $display("FAIL override p=%0d c=%0d led=%b/%b mode=%0d/%0d press=%b/%b", p, c, led, m_led, mode_o, m_mode, press_o, m_press);
        end
        if (c == lo - 1) button = 2'b11;
      end
    end
    n_checks++;
    if (n_both !== 1 || n_single !== 0 || mode_o !== 3'd0 || led[0] !== 1'b0) begin
      n_errors++;
      $display("FAIL both_press both=%0d single=%0d mode=%0d led0=%b required 1/0/0/0", n_both, n_single, mode_o, led[0]);
    end
  endtask

  task automatic test_breathe();
    int on_cnt;
    for (int p = 0; p < 4; p++) begin
      int lo;
      lo = 6 + int'($urandom_range(0, 3));
      button = 2'b10;
      for (int c = 0; c < lo + 10; c++) begin
        @(negedge clk);
        n_checks++;
        if (led !== m_led || mode_o !== 3'(m_mode) || press_o !== m_press) begin
          n_errors++;
          $display("FAIL breathe_entry p=%0d c=%0d led=%b/%b mode=%0d/%0d press=%b/%b", p, c, led, m_led, mode_o, m_mode, press_o, m_press);
        end
        if (c == lo - 1) button = 2'b11;
      end
    end
    on_cnt = 0;
    for (int c = 0; c < 600 + int'($urandom_range(0, 100)); c++) begin
      @(negedge clk);
      if (led[0]) on_cnt++;
      n_checks++;
      if (led !== m_led || mode_o !== 3'(m_mode) || press_o !== m_press) begin
        n_errors++;
        $display("FAIL breathe c=%0d led=%b/%b mode=%0d/%0d duty_model=%0d", c, led, m_led, mode_o, m_mode, tri_duty(m_j));
      end
    end
    n_checks++;
    if (mode_o !== 3'd4 || on_cnt == 0) begin
      n_errors++;
      $display("FAIL breathe_active mode=%0d on_cycles=%0d required 4/nonzero", mode_o, on_cnt);
    end
  endtask

  task automatic test_async_reset();
    int seen;
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    n_checks++;
    if (led !== 2'b00 || mode_o !== 3'd0 || press_o !== 2'b00) begin
      n_errors++;
      $display("FAIL async_reset led=%b mode=%0d press=%b required 00/0/00", led, mode_o, press_o);
    end
    for (int c = 0; c < 3; c++) @(negedge clk);
    rst = 1'b1;
    seen = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (press_o != 2'b00) seen++;
      n_checks++;
      if (led !== m_led || mode_o !== 3'(m_mode) || press_o !== m_press) begin
        n_errors++;
        $display("FAIL after_reset c=%0d led=%b/%b mode=%0d/%0d press=%b/%b", c, led, m_led, mode_o, m_mode, press_o, m_press);
      end
    end
    n_checks++;
    if (seen !== 0 || mode_o !== 3'd0) begin
      n_errors++;
      $display("FAIL reset_nopress pulses=%0d mode=%0d required 0/0", seen, mode_o);
    end
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_mode_cycle();
    test_override();
    test_breathe();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
